// File: rtl/dma_mem_arbiter_if.sv
// Bundle of the three requester ports and the shared memory bus of dma_mem_arbiter.
// The master modport is the arbiter's view; slave is the requesters plus memory.
interface dma_mem_arbiter_if;
  logic        instr_m_access;
  logic [19:1] instr_m_addr;
  logic        instr_m_ack;
  logic [15:0] instr_m_data_in;

  logic        data_m_access;
  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_out;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic        data_m_ack;
  logic [15:0] data_m_data_in;

  logic        dma_m_access;
  logic [19:1] dma_m_addr;
  logic [15:0] dma_m_data_out;
  logic        dma_m_wr_en;
  logic [1:0]  dma_m_bytesel;
  logic        dma_m_ack;
  logic [15:0] dma_m_data_in;

  logic        q_m_access;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_out;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_m_ack;
  logic [15:0] q_m_data_in;

  modport master (
    input  instr_m_access, instr_m_addr,
    output instr_m_ack, instr_m_data_in,
    input  data_m_access, data_m_addr, data_m_data_out, data_m_wr_en, data_m_bytesel,
    output data_m_ack, data_m_data_in,
    input  dma_m_access, dma_m_addr, dma_m_data_out, dma_m_wr_en, dma_m_bytesel,
    output dma_m_ack, dma_m_data_in,
    output q_m_access, q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel,
    input  q_m_ack, q_m_data_in
  );

  modport slave (
    output instr_m_access, instr_m_addr,
    input  instr_m_ack, instr_m_data_in,
    output data_m_access, data_m_addr, data_m_data_out, data_m_wr_en, data_m_bytesel,
    input  data_m_ack, data_m_data_in,
    output dma_m_access, dma_m_addr, dma_m_data_out, dma_m_wr_en, dma_m_bytesel,
    input  dma_m_ack, dma_m_data_in,
    input  q_m_access, q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel,
    output q_m_ack, q_m_data_in
  );
endinterface

// File: rtl/dma_mem_arbiter.sv
// Round-robin arbiter of instruction, data and DMA requesters onto one memory bus,
// with ack timeout. DMA port arbitrated only when CONFIG_ARB_DMA_EN is defined.
module dma_mem_arbiter #(
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  dma_mem_arbiter_if.master bus,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, GRANT_M} state_t;

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  state_t        r_state;
  state_t        r_last;
  logic [CW-1:0] r_wait;
  logic          r_q_access;
  logic          r_timeout_err;

  state_t        w_state_nxt;
  state_t        w_pick;
  logic          w_req_i;
  logic          w_req_d;
  logic          w_req_m;
  logic          w_tmo_hit;
  logic          w_done;
  logic          w_tmo;
  logic [15:0]   w_rd_data;

  assign w_req_i = bus.instr_m_access;
  assign w_req_d = bus.data_m_access;
`ifdef CONFIG_ARB_DMA_EN
  assign w_req_m = bus.dma_m_access;
`else
  assign w_req_m = 1'b0;
`endif

  assign w_tmo_hit = (ACK_TIMEOUT != 0) && (r_wait == CW'(ACK_TIMEOUT));

  // Search starts just after the last owner: I -> D -> M -> I.
  always_comb begin
    w_pick = IDLE;
    case (r_last)
      GRANT_I: begin
        if (w_req_d)      w_pick = GRANT_D;
        else if (w_req_m) w_pick = GRANT_M;
        else if (w_req_i) w_pick = GRANT_I;
      end
      GRANT_D: begin
        if (w_req_m)      w_pick = GRANT_M;
        else if (w_req_i) w_pick = GRANT_I;
        else if (w_req_d) w_pick = GRANT_D;
      end
      default: begin
        if (w_req_i)      w_pick = GRANT_I;
        else if (w_req_d) w_pick = GRANT_D;
        else if (w_req_m) w_pick = GRANT_M;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    if (r_state == IDLE) begin
      w_state_nxt = w_pick;
    end else if (bus.q_m_ack) begin
      w_done      = 1'b1;
      w_state_nxt = IDLE;
    end else if (w_tmo_hit) begin
      w_done      = 1'b1;
      w_tmo       = 1'b1;
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_last        <= GRANT_M;
      r_wait        <= '0;
      r_q_access    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_q_access <= (w_state_nxt != IDLE);
      if (r_state != IDLE && w_done) r_last <= r_state;
      if (r_state == IDLE || w_state_nxt == IDLE)
        r_wait <= '0;
      else if (ACK_TIMEOUT != 0)
        r_wait <= r_wait + 1'b1;
      if (w_tmo) r_timeout_err <= 1'b1;
    end
  end

  always_comb begin
    bus.q_m_addr     = '0;
    bus.q_m_data_out = '0;
    bus.q_m_wr_en    = 1'b0;
    bus.q_m_bytesel  = 2'b00;
    case (r_state)
      GRANT_I: begin
        bus.q_m_addr    = bus.instr_m_addr;
        bus.q_m_bytesel = 2'b11;
      end
      GRANT_D: begin
        bus.q_m_addr     = bus.data_m_addr;
        bus.q_m_data_out = bus.data_m_data_out;
        bus.q_m_wr_en    = bus.data_m_wr_en;
        bus.q_m_bytesel  = bus.data_m_bytesel;
      end
`ifdef CONFIG_ARB_DMA_EN
      GRANT_M: begin
        bus.q_m_addr     = bus.dma_m_addr;
        bus.q_m_data_out = bus.dma_m_data_out;
        bus.q_m_wr_en    = bus.dma_m_wr_en;
        bus.q_m_bytesel  = bus.dma_m_bytesel;
      end
`endif
      default: ;
    endcase
  end

  assign bus.q_m_access = r_q_access;
  assign w_rd_data      = w_tmo ? 16'hFFFF : bus.q_m_data_in;

  assign bus.instr_m_ack     = w_done && (r_state == GRANT_I);
  assign bus.instr_m_data_in = bus.instr_m_ack ? w_rd_data : 16'h0000;
  assign bus.data_m_ack      = w_done && (r_state == GRANT_D);
  assign bus.data_m_data_in  = bus.data_m_ack ? w_rd_data : 16'h0000;
`ifdef CONFIG_ARB_DMA_EN
  assign bus.dma_m_ack       = w_done && (r_state == GRANT_M);
  assign bus.dma_m_data_in   = bus.dma_m_ack ? w_rd_data : 16'h0000;
`else
  assign bus.dma_m_ack       = 1'b0;
  assign bus.dma_m_data_in   = 16'h0000;
`endif

  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Directed bench for dma_mem_arbiter (ACK_TIMEOUT=8); expectations adapt to CONFIG_ARB_DMA_EN.
module tb_dma_mem_arbiter;
  logic clk;
  logic reset;
  logic timeout_err;
  int   checks;
  int   failures;

  dma_mem_arbiter_if bus();

  dma_mem_arbiter #(.ACK_TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.instr_m_access  = 1'b0;
    bus.instr_m_addr    = '0;
    bus.data_m_access   = 1'b0;
    bus.data_m_addr     = '0;
    bus.data_m_data_out = '0;
    bus.data_m_wr_en    = 1'b0;
    bus.data_m_bytesel  = 2'b00;
    bus.dma_m_access    = 1'b0;
    bus.dma_m_addr      = '0;
    bus.dma_m_data_out  = '0;
    bus.dma_m_wr_en     = 1'b0;
    bus.dma_m_bytesel   = 2'b00;
    bus.q_m_ack         = 1'b0;
    bus.q_m_data_in     = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    bus.instr_m_access = 1'b1;
    tick();
    tick();
    checks++; if (bus.q_m_access !== 1'b0) begin failures++; $display("FAIL rst_q_access got=%b exp=0", bus.q_m_access); end
    checks++; if (bus.q_m_addr !== 19'h0) begin failures++; $display("FAIL rst_q_addr got=%h exp=0", bus.q_m_addr); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout_err got=%b exp=0", timeout_err); end
    checks++; if ({bus.instr_m_ack, bus.data_m_ack, bus.dma_m_ack} !== 3'b000) begin
      failures++; $display("FAIL rst_acks got=%b exp=000", {bus.instr_m_ack, bus.data_m_ack, bus.dma_m_ack}); end
    bus.instr_m_access = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (bus.q_m_bytesel !== 2'b00) begin failures++; $display("FAIL rst_q_bytesel got=%b exp=00", bus.q_m_bytesel); end
  endtask

  task automatic test_single_read();
    int hi;
    bit early;
    hi = 0;
    early = 1'b0;
    bus.instr_m_addr   = 19'h7FFF0;
    bus.instr_m_access = 1'b1;
    #1;
    checks++; if (bus.q_m_access !== 1'b0) begin failures++; $display("FAIL sr_pre_grant got=%b exp=0", bus.q_m_access); end
    tick();
    checks++; if (bus.q_m_addr !== 19'h7FFF0) begin failures++; $display("FAIL sr_q_addr got=%h exp=7fff0", bus.q_m_addr); end
    checks++; if (bus.q_m_bytesel !== 2'b11) begin failures++; $display("FAIL sr_q_bytesel got=%b exp=11", bus.q_m_bytesel); end
    checks++; if (bus.q_m_wr_en !== 1'b0) begin failures++; $display("FAIL sr_q_wr_en got=%b exp=0", bus.q_m_wr_en); end
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        bus.q_m_ack     = 1'b1;
        bus.q_m_data_in = 16'hBEEF;
      end
      #1;
      if (bus.q_m_access === 1'b1) hi++;
      if (c < 3 && bus.instr_m_ack !== 1'b0) early = 1'b1;
      if (c == 3) begin
        checks++; if (bus.instr_m_ack !== 1'b1) begin failures++; $display("FAIL sr_ack got=%b exp=1", bus.instr_m_ack); end
        checks++; if (bus.instr_m_data_in !== 16'hBEEF) begin failures++; $display("FAIL sr_data got=%h exp=beef", bus.instr_m_data_in); end
      end
      tick();
    end
    bus.q_m_ack        = 1'b0;
    bus.instr_m_access = 1'b0;
    #1;
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL sr_early_ack got=%b exp=0", early); end
    checks++; if (hi !== 4) begin failures++; $display("FAIL sr_access_cycles got=%0d exp=4", hi); end
    checks++; if (bus.q_m_access !== 1'b0) begin failures++; $display("FAIL sr_idle_access got=%b exp=0", bus.q_m_access); end
    checks++; if (bus.instr_m_ack !== 1'b0 || bus.instr_m_data_in !== 16'h0) begin
      failures++; $display("FAIL sr_after_ack got=%b/%h exp=0/0000", bus.instr_m_ack, bus.instr_m_data_in); end
  endtask

  task automatic test_write();
    bus.data_m_addr     = 19'h00010;
    bus.data_m_data_out = 16'h1234;
    bus.data_m_bytesel  = 2'b01;
    bus.data_m_wr_en    = 1'b1;
    bus.data_m_access   = 1'b1;
    tick();
    checks++; if (bus.q_m_access !== 1'b1) begin failures++; $display("FAIL wr_q_access got=%b exp=1", bus.q_m_access); end
    checks++; if (bus.q_m_addr !== 19'h00010) begin failures++; $display("FAIL wr_q_addr got=%h exp=00010", bus.q_m_addr); end
    checks++; if (bus.q_m_data_out !== 16'h1234) begin failures++; $display("FAIL wr_q_data got=%h exp=1234", bus.q_m_data_out); end
    checks++; if (bus.q_m_wr_en !== 1'b1) begin failures++; $display("FAIL wr_q_wr_en got=%b exp=1", bus.q_m_wr_en); end
    checks++; if (bus.q_m_bytesel !== 2'b01) begin failures++; $display("FAIL wr_q_bytesel got=%b exp=01", bus.q_m_bytesel); end
    bus.q_m_ack = 1'b1;
    #1;
    checks++; if ({bus.instr_m_ack, bus.data_m_ack, bus.dma_m_ack} !== 3'b010) begin
      failures++; $display("FAIL wr_acks got=%b exp=010", {bus.instr_m_ack, bus.data_m_ack, bus.dma_m_ack}); end
    tick();
    bus.q_m_ack       = 1'b0;
    bus.data_m_access = 1'b0;
    bus.data_m_wr_en  = 1'b0;
    #1;
    checks++; if (bus.q_m_access !== 1'b0 || bus.q_m_wr_en !== 1'b0) begin
      failures++; $display("FAIL wr_idle got=%b/%b exp=0/0", bus.q_m_access, bus.q_m_wr_en); end
  endtask

  task automatic test_idle_ack();
    bus.q_m_ack     = 1'b1;
    bus.q_m_data_in = 16'hA5A5;
    #1;
    checks++; if ({bus.instr_m_ack, bus.data_m_ack, bus.dma_m_ack} !== 3'b000) begin
      failures++; $display("FAIL ia_acks got=%b exp=000", {bus.instr_m_ack, bus.data_m_ack, bus.dma_m_ack}); end
    checks++; if (bus.instr_m_data_in !== 16'h0 || bus.data_m_data_in !== 16'h0) begin
      failures++; $display("FAIL ia_data got=%h/%h exp=0000/0000", bus.instr_m_data_in, bus.data_m_data_in); end
    tick();
    bus.q_m_ack = 1'b0;
    #1;
    checks++; if (bus.q_m_access !== 1'b0) begin failures++; $display("FAIL ia_access got=%b exp=0", bus.q_m_access); end
  endtask

  task automatic test_contention();
    logic [19:1] exp_addr [6];
    logic [2:0]  exp_ack  [6];
    bit          dma_seen;
    dma_seen = 1'b0;
`ifdef CONFIG_ARB_DMA_EN
    exp_addr = '{19'h1, 19'h2, 19'h3, 19'h1, 19'h2, 19'h3};
    exp_ack  = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
`else
    exp_addr = '{19'h1, 19'h2, 19'h1, 19'h2, 19'h1, 19'h2};
    exp_ack  = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
`endif
    reset = 1'b1;
    #1;
    reset = 1'b0;
    bus.instr_m_addr   = 19'h1;
    bus.data_m_addr    = 19'h2;
    bus.dma_m_addr     = 19'h3;
    bus.dma_m_bytesel  = 2'b10;
    bus.instr_m_access = 1'b1;
    bus.data_m_access  = 1'b1;
    bus.dma_m_access   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.dma_m_ack === 1'b1) dma_seen = 1'b1;
      checks++; if (bus.q_m_access !== 1'b1 || bus.q_m_addr !== exp_addr[k]) begin
        failures++; $display("FAIL ct_grant%0d got=%b/%h exp=1/%h", k, bus.q_m_access, bus.q_m_addr, exp_addr[k]); end
      tick();
      bus.q_m_ack     = 1'b1;
      bus.q_m_data_in = 16'h1000 + 16'(k);
      #1;
      if (bus.dma_m_ack === 1'b1) dma_seen = 1'b1;
      checks++; if ({bus.instr_m_ack, bus.data_m_ack, bus.dma_m_ack} !== exp_ack[k]) begin
        failures++; $display("FAIL ct_ack%0d got=%b exp=%b", k, {bus.instr_m_ack, bus.data_m_ack, bus.dma_m_ack}, exp_ack[k]); end
      tick();
      bus.q_m_ack = 1'b0;
      if (k == 5) begin
        bus.instr_m_access = 1'b0;
        bus.data_m_access  = 1'b0;
        bus.dma_m_access   = 1'b0;
      end
      #1;
      checks++; if (bus.q_m_access !== 1'b0) begin failures++; $display("FAIL ct_idle%0d got=%b exp=0", k, bus.q_m_access); end
    end
`ifdef CONFIG_ARB_DMA_EN
    checks++; if (dma_seen !== 1'b1) begin failures++; $display("FAIL ct_dma_ack got=%b exp=1", dma_seen); end
`else
    checks++; if (dma_seen !== 1'b0) begin failures++; $display("FAIL ct_dma_ack got=%b exp=0", dma_seen); end
`endif
  endtask

  task automatic test_timeout();
    bit early;
    early = 1'b0;
    bus.data_m_addr   = 19'h00055;
    bus.data_m_access = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) begin
      if (bus.data_m_ack !== 1'b0 || bus.q_m_access !== 1'b1) early = 1'b1;
      tick();
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", early); end
    checks++; if (bus.data_m_ack !== 1'b1) begin failures++; $display("FAIL to_ack got=%b exp=1", bus.data_m_ack); end
    checks++; if (bus.data_m_data_in !== 16'hFFFF) begin failures++; $display("FAIL to_data got=%h exp=ffff", bus.data_m_data_in); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_err_early got=%b exp=0", timeout_err); end
    tick();
    bus.data_m_access = 1'b0;
    #1;
    checks++; if (timeout_err !== 1'b1 || bus.q_m_access !== 1'b0) begin
      failures++; $display("FAIL to_err got=%b/%b exp=1/0", timeout_err, bus.q_m_access); end
    tick();
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    bus.instr_m_addr   = 19'h00123;
    bus.instr_m_access = 1'b1;
    tick();
    bus.q_m_ack = 1'b1;
    tick();
    bus.q_m_ack        = 1'b0;
    bus.instr_m_access = 1'b0;
    bus.data_m_addr    = 19'h00456;
    bus.data_m_access  = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (bus.q_m_access !== 1'b1 || bus.q_m_addr !== 19'h00456) begin
      failures++; $display("FAIL rm_grant_d got=%b/%h exp=1/00456", bus.q_m_access, bus.q_m_addr); end
    reset = 1'b1;
    #1;
    checks++; if (bus.q_m_access !== 1'b0 || bus.q_m_addr !== 19'h0) begin
      failures++; $display("FAIL rm_q_clear got=%b/%h exp=0/00000", bus.q_m_access, bus.q_m_addr); end
    checks++; if ({bus.instr_m_ack, bus.data_m_ack, bus.dma_m_ack} !== 3'b000) begin
      failures++; $display("FAIL rm_acks got=%b exp=000", {bus.instr_m_ack, bus.data_m_ack, bus.dma_m_ack}); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rm_err got=%b exp=0", timeout_err); end
    tick();
    reset = 1'b0;
    bus.instr_m_access = 1'b1;
    tick();
    checks++; if (bus.q_m_access !== 1'b1 || bus.q_m_addr !== 19'h00123) begin
      failures++; $display("FAIL rm_next_i got=%b/%h exp=1/00123", bus.q_m_access, bus.q_m_addr); end
    bus.q_m_ack = 1'b1;
    tick();
    bus.q_m_ack        = 1'b0;
    bus.instr_m_access = 1'b0;
    bus.data_m_access  = 1'b0;
    tick();
  endtask

  task automatic test_ack_with_timeout();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    bus.instr_m_addr   = 19'h00077;
    bus.instr_m_access = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) tick();
    bus.q_m_ack     = 1'b1;
    bus.q_m_data_in = 16'h5A5A;
    #1;
    checks++; if (bus.instr_m_ack !== 1'b1 || bus.instr_m_data_in !== 16'h5A5A) begin
      failures++; $display("FAIL at_ack got=%b/%h exp=1/5a5a", bus.instr_m_ack, bus.instr_m_data_in); end
    tick();
    bus.q_m_ack        = 1'b0;
    bus.instr_m_access = 1'b0;
    #1;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL at_err got=%b exp=0", timeout_err); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_read();
    test_write();
    test_idle_ack();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_ack_with_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
